// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first, txd idles high).
// rstn is an asynchronous reset that is active HIGH despite its name.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    io_out_data,
  input  logic                          io_out_vld,
  output logic                          io_out_rdy,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int CW    = $clog2(CLK_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1'b1);
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]    BAUD_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]    BAUD_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_rdy;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [7:0]       w_head;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_baud;
  logic [CW-1:0]    w_baud_nxt;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_nxt;
  logic [2:0]       w_bit_inc;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_txd;
  logic             w_txd_nxt;
  logic             r_busy;
  logic             w_baud_last;

  assign w_push      = io_out_vld & r_rdy;
  assign w_empty     = (r_count == CNT_ZERO);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_bit_inc   = r_bit + 3'd1;

  assign io_out_rdy  = r_rdy;
  assign txd         = r_txd;
  assign tx_busy     = r_busy;
  assign fifo_count  = r_count;

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state logic; txd is precomputed for the state being entered so it can be registered.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = BAUD_ZERO;
        w_bit_nxt  = 3'd0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_txd_nxt   = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = BAUD_ZERO;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
        end else begin
          w_baud_nxt  = r_baud + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_nxt = BAUD_ZERO;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = w_bit_inc;
            w_txd_nxt   = r_shift[w_bit_inc];
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_nxt = BAUD_ZERO;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BAUD_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = BAUD_ZERO;
        w_bit_nxt   = 3'd0;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  // FIFO storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_out_data;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= CNT_ZERO;
      r_rdy    <= 1'b0;
      r_state  <= S_IDLE;
      r_baud   <= BAUD_ZERO;
      r_bit    <= 3'd0;
      r_shift  <= 8'h00;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count  <= w_count_nxt;
      r_rdy    <= (w_count_nxt != CNT_FULL);
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
